lsu_mem_initiator: RTL and testbench

Load/store initiator that drives the byte-addressed, 64-bit little-endian data-memory port (Mem_Addr, Write_Data, MemWrite, MemRead, Read_Data) from the MEM stage.
Accepts one request at a time over a valid/ready handshake and checks alignment and range.
Stores narrower than 64 bits use read-modify-write, because the memory writes all 8 bytes.
Loads are lane-extracted and sign- or zero-extended before returning on a valid/ready response channel.

---
 rtl/lsu_mem_initiator.sv | 211 +++++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for a 64-bit little-endian, byte-addressed data memory port.
// Optional performance counters are enabled with `define LSU_PERF_CNT_EN.
module lsu_mem_initiator #(
    parameter int ADDR_LIMIT = 256,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [63:0]      req_addr,
    input  logic [63:0]      req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic             rsp_err,
    output logic [63:0]      Mem_Addr,
    output logic [63:0]      Write_Data,
    output logic             MemWrite,
    output logic             MemRead,
    input  logic [63:0]      Read_Data,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RSP = 2'd3} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_misalign;
    logic        w_range;
    logic        w_err;
    logic [64:0] w_end;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [2:0]  r_off;
    logic [63:0] r_wdata;

    // Pull the addressed lane down to bit 0 and sign- or zero-extend it.
    function automatic logic [63:0] f_lane_extend(input logic [63:0] d, input logic [1:0] size,
                                                  input logic [2:0] off, input logic uns);
        logic [63:0] sh;
        logic [63:0] res;
        sh = d >> {off, 3'b000};
        case (size)
            2'd0:    res = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
            2'd1:    res = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    res = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // Replace only the target lanes of the read doubleword with the store data.
    function automatic logic [63:0] f_lane_merge(input logic [63:0] d, input logic [63:0] wd,
                                                 input logic [1:0] size, input logic [2:0] off);
        logic [63:0] mask;
        case (size)
            2'd0:    mask = 64'h0000_0000_0000_00FF;
            2'd1:    mask = 64'h0000_0000_0000_FFFF;
            2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return (d & ~(mask << {off, 3'b000})) | ((wd & mask) << {off, 3'b000});
    endfunction

    // Accept decode with alignment and range checks; end address is 65 bits so it cannot wrap.
    always_comb begin
        w_accept = req_valid && (r_state == IDLE);
        w_end    = {1'b0, req_addr} + (65'd1 << req_size);
        case (req_size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = req_addr[0];
            2'd2:    w_misalign = |req_addr[1:0];
            default: w_misalign = |req_addr[2:0];
        endcase
        w_range = (w_end > 65'(ADDR_LIMIT));
        w_err   = w_misalign | w_range;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; only narrow stores and loads visit RD.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err)                                w_next = RSP;
                    else if (req_write && req_size == 2'd3)   w_next = WR;
                    else                                      w_next = RD;
                end else begin
                    w_next = IDLE;
                end
            end
            RD:      w_next = r_write ? WR : RSP;
            WR:      w_next = RSP;
            RSP:     w_next = rsp_ready ? IDLE : RSP;
            default: w_next = IDLE;
        endcase
    end

    assign req_ready = (r_state == IDLE);

    // Request capture, memory strobes and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write    <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_off      <= 3'd0;
            r_wdata    <= 64'd0;
            Mem_Addr   <= 64'd0;
            Write_Data <= 64'd0;
            MemWrite   <= 1'b0;
            MemRead    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 64'd0;
            rsp_err    <= 1'b0;
        end else begin
            MemRead   <= (w_next == RD);
            MemWrite  <= (w_next == WR);
            rsp_valid <= (w_next == RSP);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_off      <= req_addr[2:0];
                        r_wdata    <= req_wdata;
                        rsp_err    <= w_err;
                        rsp_data   <= 64'd0;
                        if (w_err) begin
                            Mem_Addr   <= 64'd0;
                            Write_Data <= 64'd0;
                        end else begin
                            Mem_Addr   <= {req_addr[63:3], 3'b000};
                            Write_Data <= (req_write && req_size == 2'd3) ? req_wdata : 64'd0;
                        end
                    end
                end
                RD: begin
                    if (r_write) begin
                        Write_Data <= f_lane_merge(Read_Data, r_wdata, r_size, r_off);
                    end else begin
                        rsp_data <= f_lane_extend(Read_Data, r_size, r_off, r_unsigned);
                        Mem_Addr <= 64'd0;
                    end
                end
                WR: begin
                    Write_Data <= 64'd0;
                    Mem_Addr   <= 64'd0;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_err  <= 1'b0;
                        rsp_data <= 64'd0;
                    end
                end
                default: begin
                    Mem_Addr   <= 64'd0;
                    Write_Data <= 64'd0;
                end
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    logic [CNT_W-1:0] r_load_cnt;
    logic [CNT_W-1:0] r_store_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    // Count completed response handshakes by kind; errors count only as errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load_cnt  <= {CNT_W{1'b0}};
            r_store_cnt <= {CNT_W{1'b0}};
            r_err_cnt   <= {CNT_W{1'b0}};
        end else if (r_state == RSP && rsp_ready) begin
            if (rsp_err)      r_err_cnt   <= r_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            else if (r_write) r_store_cnt <= r_store_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            else              r_load_cnt  <= r_load_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_load_cnt <= r_load_cnt;
        end
    end

    assign load_count  = r_load_cnt;
    assign store_count = r_store_cnt;
    assign err_count   = r_err_cnt;
`else
    assign load_count  = {CNT_W{1'b0}};
    assign store_count = {CNT_W{1'b0}};
    assign err_count   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed self-checking bench for lsu_mem_initiator with a 256-byte memory model.
module tb_lsu_mem_initiator;

    localparam int CNT_W = 32;
`ifdef LSU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]       req_size;
    logic [63:0]      req_addr, req_wdata;
    logic             rsp_valid, rsp_ready, rsp_err;
    logic [63:0]      rsp_data, Mem_Addr, Write_Data, Read_Data;
    logic             MemWrite, MemRead;
    logic [CNT_W-1:0] load_count, store_count, err_count;

    logic [63:0] mem [0:31];
    int          n_checks = 0;
    int          n_pass = 0;
    int          rd_tot = 0, wr_tot = 0, both_tot = 0, wd_bad = 0, ma_bad = 0;
    logic [63:0] last_maddr = 64'd0, last_wdata = 64'd0;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.ADDR_LIMIT(256), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .Mem_Addr(Mem_Addr),
        .Write_Data(Write_Data), .MemWrite(MemWrite), .MemRead(MemRead),
        .Read_Data(Read_Data), .load_count(load_count), .store_count(store_count),
        .err_count(err_count)
    );

    assign Read_Data = mem[Mem_Addr[7:3]];

    // Memory commit plus bus monitor.
    always @(posedge clk) begin
        if (MemWrite) mem[Mem_Addr[7:3]] <= Write_Data;
        if (MemRead) rd_tot <= rd_tot + 1;
        if (MemWrite) begin
            wr_tot     <= wr_tot + 1;
            last_wdata <= Write_Data;
        end
        if (MemRead || MemWrite) last_maddr <= Mem_Addr;
        if (MemRead && MemWrite) both_tot <= both_tot + 1;
        if (!MemWrite && Write_Data != 64'd0) wd_bad <= wd_bad + 1;
        if (!MemRead && !MemWrite && Mem_Addr != 64'd0) ma_bad <= ma_bad + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic run(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] exp_d, input logic exp_e, input int exp_lat,
                       input int exp_rd, input int exp_wr, input logic [63:0] exp_ma,
                       input logic [63:0] exp_wdat, input int hold);
        int          rd0, wr0, lat;
        logic [63:0] data;
        logic        err;
        @(negedge clk);
        rd0 = rd_tot;
        wr0 = wr_tot;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~wr; req_size = ~sz; req_unsigned = ~uns;
        req_addr = 64'hFFFF_FFFF_FFFF_FFF8; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        data = rsp_data;
        err  = rsp_err;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, data, exp_d);
        chk({tag, "_err"}, {63'd0, err}, {63'd0, exp_e});
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            @(negedge clk);
            chk({tag, "_hold_valid"}, {63'd0, rsp_valid}, 64'd1);
            chk({tag, "_hold_data"}, rsp_data, data);
            chk({tag, "_hold_ready"}, {63'd0, req_ready}, 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, {63'd0, rsp_valid}, 64'd0);
        chk({tag, "_nrd"}, 64'(rd_tot - rd0), 64'(exp_rd));
        chk({tag, "_nwr"}, 64'(wr_tot - wr0), 64'(exp_wr));
        if (exp_rd + exp_wr > 0) chk({tag, "_maddr"}, last_maddr, exp_ma);
        if (exp_wr > 0) chk({tag, "_wdata"}, last_wdata, exp_wdat);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 64'd0;
        mem[0]  = 64'h0000_0000_0000_0001;
        mem[1]  = 64'h0000_0000_0000_0080;
        mem[2]  = 64'h0000_0000_0000_0003;
        mem[31] = 64'h1111_2222_3333_4444;
        #12;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_maddr", Mem_Addr, 64'd0);
        chk("rst_wdata", Write_Data, 64'd0);
        chk("rst_strobes", {62'd0, MemRead, MemWrite}, 64'd0);
        chk("rst_rsp", {62'd0, rsp_valid, rsp_err}, 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        //   tag          wr    sz    uns   addr     wdata                   exp_data                exp_e lat rd wr maddr   exp_wdata               hold
        run("ld_d0",      1'b0, 2'd3, 1'b0, 64'd0,   64'd0,                  64'h1,                  1'b0, 2, 1, 0, 64'd0,   64'd0,                  0);
        run("ld_b8_s",    1'b0, 2'd0, 1'b0, 64'd8,   64'd0,                  64'hFFFF_FFFF_FFFF_FF80,1'b0, 2, 1, 0, 64'd8,   64'd0,                  0);
        run("ld_b8_u",    1'b0, 2'd0, 1'b1, 64'd8,   64'd0,                  64'h80,                 1'b0, 2, 1, 0, 64'd8,   64'd0,                  0);
        run("st_b19",     1'b1, 2'd0, 1'b0, 64'd19,  64'h1234_5678_9ABC_DEAB,64'd0,                  1'b0, 3, 1, 1, 64'd16,  64'h0000_0000_AB00_0003,0);
        run("ld_d16",     1'b0, 2'd3, 1'b0, 64'd16,  64'd0,                  64'h0000_0000_AB00_0003,1'b0, 2, 1, 0, 64'd16,  64'd0,                  0);
        run("ld_h5_err",  1'b0, 2'd1, 1'b0, 64'd5,   64'd0,                  64'd0,                  1'b1, 1, 0, 0, 64'd0,   64'd0,                  0);
        run("st_d252_err",1'b1, 2'd3, 1'b0, 64'd252, 64'h5555_5555_5555_5555,64'd0,                  1'b1, 1, 0, 0, 64'd0,   64'd0,                  0);
        run("st_w252",    1'b1, 2'd2, 1'b0, 64'd252, 64'hCAFE_BABE_DEAD_BEEF,64'd0,                  1'b0, 3, 1, 1, 64'd248, 64'hDEAD_BEEF_3333_4444,0);
        run("ld_h254_s",  1'b0, 2'd1, 1'b0, 64'd254, 64'd0,                  64'hFFFF_FFFF_FFFF_DEAD,1'b0, 2, 1, 0, 64'd248, 64'd0,                  0);
        run("ld_w256_err",1'b0, 2'd2, 1'b1, 64'd256, 64'd0,                  64'd0,                  1'b1, 1, 0, 0, 64'd0,   64'd0,                  0);
        run("bp_ld_d0",   1'b0, 2'd3, 1'b0, 64'd0,   64'd0,                  64'h1,                  1'b0, 2, 1, 0, 64'd0,   64'd0,                  5);

        chk("cnt_load_a",  64'(load_count),  PERF ? 64'd6 : 64'd0);
        chk("cnt_store_a", 64'(store_count), PERF ? 64'd2 : 64'd0);
        chk("cnt_err_a",   64'(err_count),   PERF ? 64'd3 : 64'd0);

        // Reset cuts a double store in its WR cycle.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 64'd0; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rstwr_strobe", {63'd0, MemWrite}, 64'd1);
        reset = 1'b0;
        #1;
        chk("rstwr_memwrite", {63'd0, MemWrite}, 64'd0);
        chk("rstwr_memread", {63'd0, MemRead}, 64'd0);
        chk("rstwr_idle", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rstwr_no_rsp", {63'd0, rsp_valid}, 64'd0);
        chk("rstwr_mem0", mem[0], 64'h1);
        chk("cnt_load_rst", 64'(load_count), 64'd0);

        run("p_ld_d0",    1'b0, 2'd3, 1'b0, 64'd0,   64'd0,                  64'h1,                  1'b0, 2, 1, 0, 64'd0,   64'd0,                  0);
        run("p_ld_w0_s",  1'b0, 2'd2, 1'b0, 64'd0,   64'd0,                  64'h1,                  1'b0, 2, 1, 0, 64'd0,   64'd0,                  0);
        run("p_ld_b9_u",  1'b0, 2'd0, 1'b1, 64'd9,   64'd0,                  64'd0,                  1'b0, 2, 1, 0, 64'd8,   64'd0,                  0);
        run("p_st_h2",    1'b1, 2'd1, 1'b0, 64'd2,   64'hCAFE_0000_0000_1234,64'd0,                  1'b0, 3, 1, 1, 64'd0,   64'h0000_0000_1234_0001,0);
        run("p_st_d8",    1'b1, 2'd3, 1'b0, 64'd8,   64'h0123_4567_89AB_CDEF,64'd0,                  1'b0, 2, 0, 1, 64'd8,   64'h0123_4567_89AB_CDEF,0);
        run("p_ld_b256",  1'b0, 2'd0, 1'b1, 64'd256, 64'd0,                  64'd0,                  1'b1, 1, 0, 0, 64'd0,   64'd0,                  0);

        chk("cnt_load_b",  64'(load_count),  PERF ? 64'd3 : 64'd0);
        chk("cnt_store_b", 64'(store_count), PERF ? 64'd2 : 64'd0);
        chk("cnt_err_b",   64'(err_count),   PERF ? 64'd1 : 64'd0);
        chk("mem8_final", mem[1], 64'h0123_4567_89AB_CDEF);
        chk("strobe_overlap", 64'(both_tot), 64'd0);
        chk("wdata_outside_wr", 64'(wd_bad), 64'd0);
        chk("maddr_when_idle", 64'(ma_bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
